sram_loader: RTL and testbench

Bus-master SRAM loader for the Z8S180 board FPGA. Requests the CPU bus via /BUSREQ, waits for /BUSACK, writes a byte stream from an on-FPGA source into the external static RAM at a configured base address, then releases the bus so the CPU can run the loaded image. It is the initiator counterpart of the FPGA's memory-responder glue: the FPGA drives address, data and SRAM strobes instead of decoding them. Top level muxes `a`, `d`, `ce_n`, `oe_n` and `we_n` onto the pins while `bus_oe` is high.

---
 rtl/sram_loader_pkg.sv | 30 +++
 rtl/sram_loader_sync2.sv | 26 ++
 rtl/sram_loader.sv | 214 +++++++++++++++++++++
 tb/tb_sram_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_loader_pkg.sv
// Shared types and constants for the SRAM bus-master loader.
// Readback states exist only when SRAM_LOADER_READBACK_EN is defined.
package sram_loader_pkg;

    localparam int ADDR_W            = 20;
    localparam int DATA_W            = 8;
    localparam int CNT_W             = ADDR_W + 1;
    localparam int TURNAROUND_CYCLES = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_GRANT,
        S_FETCH,
        S_SETUP,
        S_STROBE,
        S_HOLD,
`ifdef SRAM_LOADER_READBACK_EN
        S_RSETUP,
        S_RSAMPLE,
`endif
        S_RELEASE
    } state_t;

    function automatic logic [ADDR_W-1:0] sram_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  cnt);
        return base + cnt[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/sram_loader_sync2.sv
// Two-flop synchronizer for the asynchronous CPU bus acknowledge.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic hwclk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/sram_loader.sv
// Bus-master loader: grabs the CPU bus and writes a byte stream into external SRAM.
// Optional readback/checksum verify pass is enabled by SRAM_LOADER_READBACK_EN.
module sram_loader
    import sram_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 20'h00200,
    parameter int                LEN       = 512,
    parameter int                WE_CYCLES = 2
) (
    input  logic              hwclk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              busreq_n,
    input  logic              busack_n,
    output logic              bus_oe,
    output logic [ADDR_W-1:0] a_out,
    output logic [DATA_W-1:0] d_out,
    output logic              d_oe,
    input  logic [DATA_W-1:0] d_in,
    output logic              ce_n,
    output logic              oe_n,
    output logic              we_n
);

    localparam int TMR_MAX = (WE_CYCLES > TURNAROUND_CYCLES) ? WE_CYCLES : TURNAROUND_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(LEN);
    localparam logic [TMR_W-1:0] WE_LAST = TMR_W'(WE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TA_LAST = TMR_W'(TURNAROUND_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_last;
    logic [TMR_W-1:0]  r_tmr;
    logic [ADDR_W-1:0] r_a_out;
    logic [DATA_W-1:0] r_d_out;
    logic [DATA_W-1:0] r_wsum;
    logic              w_busack_n;
    logic              w_timed;

    sync2 #(.RESET_VAL(1'b1)) u_sync_ack (
        .hwclk  (hwclk),
        .reset  (reset),
        .i_async(busack_n),
        .o_sync (w_busack_n)
    );

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_last    = (w_cnt_inc == LEN_C);
    assign w_timed   = (r_state == S_GRANT) || (r_state == S_STROBE);
    assign a_out     = r_a_out;
    assign d_out     = r_d_out;

    always_ff @(posedge hwclk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // All pin controls are pure state decodes, so reset releases the bus on the same edge.
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        src_ready = 1'b0;
        busreq_n  = 1'b0;
        bus_oe    = 1'b1;
        d_oe      = 1'b0;
        ce_n      = 1'b1;
        oe_n      = 1'b1;
        we_n      = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy     = 1'b0;
                busreq_n = 1'b1;
                bus_oe   = 1'b0;
                if (start) w_next = S_REQ;
            end
            S_REQ: begin
                bus_oe = 1'b0;
                if (!w_busack_n) w_next = S_GRANT;
            end
            S_GRANT: begin
                if (r_tmr == TA_LAST) w_next = S_FETCH;
            end
            S_FETCH: begin
                src_ready = 1'b1;
                if (src_valid) w_next = S_SETUP;
            end
            S_SETUP: begin
                d_oe   = 1'b1;
                ce_n   = 1'b0;
                w_next = S_STROBE;
            end
            S_STROBE: begin
                d_oe = 1'b1;
                ce_n = 1'b0;
                we_n = 1'b0;
                if (r_tmr == WE_LAST) w_next = S_HOLD;
            end
            S_HOLD: begin
                d_oe = 1'b1;
                ce_n = 1'b0;
`ifdef SRAM_LOADER_READBACK_EN
                w_next = w_last ? S_RSETUP : S_FETCH;
`else
                w_next = w_last ? S_RELEASE : S_FETCH;
`endif
            end
`ifdef SRAM_LOADER_READBACK_EN
            S_RSETUP: begin
                ce_n   = 1'b0;
                oe_n   = 1'b0;
                w_next = S_RSAMPLE;
            end
            S_RSAMPLE: begin
                ce_n   = 1'b0;
                oe_n   = 1'b0;
                w_next = w_last ? S_RELEASE : S_RSETUP;
            end
`endif
            S_RELEASE: begin
                busreq_n = 1'b1;
                bus_oe   = 1'b0;
                done     = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                busreq_n = 1'b1;
                bus_oe   = 1'b0;
                w_next   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_tmr <= '0;
        end else if (w_timed && (w_next == r_state)) begin
            r_tmr <= r_tmr + 1'b1;
        end else begin
            r_tmr <= '0;
        end
    end

`ifdef SRAM_LOADER_READBACK_EN
    logic [DATA_W-1:0] r_rsum;
    logic              r_fail;
    assign fail = r_fail;
`else
    logic w_unused;
    assign fail     = 1'b0;
    assign w_unused = ^{d_in, r_wsum};
`endif

    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_a_out <= '0;
            r_d_out <= '0;
            r_wsum  <= '0;
`ifdef SRAM_LOADER_READBACK_EN
            r_rsum  <= '0;
            r_fail  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_cnt  <= '0;
                    r_wsum <= '0;
`ifdef SRAM_LOADER_READBACK_EN
                    r_rsum <= '0;
                    r_fail <= 1'b0;
`endif
                end
                S_FETCH: if (src_valid) begin
                    r_d_out <= src_data;
                    r_wsum  <= r_wsum + src_data;
                    r_a_out <= sram_addr(BASE_ADDR, r_cnt);
                end
                S_HOLD: begin
`ifdef SRAM_LOADER_READBACK_EN
                    // Readback pass restarts from the base address.
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_a_out <= BASE_ADDR;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
`else
                    r_cnt <= w_cnt_inc;
`endif
                end
`ifdef SRAM_LOADER_READBACK_EN
                S_RSAMPLE: begin
                    r_rsum <= r_rsum + d_in;
                    r_cnt  <= w_cnt_inc;
                    if (w_last) r_fail  <= ((r_rsum + d_in) != r_wsum);
                    else        r_a_out <= sram_addr(BASE_ADDR, w_cnt_inc);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_loader.sv
// Randomized directed bench for sram_loader: SRAM/pin monitor, source feeder, write-log scoreboard.
module tb_sram_loader;

    localparam logic [19:0] BASE = 20'h00200;
    localparam int          LEN  = 4;
    localparam int          WE   = 2;
`ifdef SRAM_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        hwclk, reset, start, busy, done, fail;
    logic        src_valid, src_ready, busreq_n, busack_n, bus_oe, d_oe, ce_n, oe_n, we_n;
    logic [7:0]  src_data, d_out, d_in;
    logic [19:0] a_out;

    sram_loader #(.BASE_ADDR(BASE), .LEN(LEN), .WE_CYCLES(WE)) dut (
        .hwclk(hwclk), .reset(reset), .start(start), .busy(busy), .done(done), .fail(fail),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .busreq_n(busreq_n), .busack_n(busack_n), .bus_oe(bus_oe),
        .a_out(a_out), .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
        .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    int n_assert = 0;
    int n_fail   = 0;

    // SRAM model and optional single-byte corruption on readback
    logic [7:0]  mem [1024];
    bit          corrupt_en;
    logic [19:0] corrupt_addr;
    assign d_in = (!ce_n && !oe_n)
                ? (mem[a_out[9:0]] ^ ((corrupt_en && a_out == corrupt_addr) ? 8'h01 : 8'h00))
                : 8'h00;

    // Source feeder: drives from a queue, optional stall before byte stall_at
    logic [7:0] src_q[$];
    int         n_cons, stall_at, stall_left;
    bit         hs;
    always @(negedge hwclk) begin
        hs = src_valid && src_ready && !reset;
        @(posedge hwclk);
        #1;
        if (hs && src_q.size() > 0) begin
            void'(src_q.pop_front());
            n_cons++;
        end
        if (src_q.size() > 0 && n_cons == stall_at && stall_left > 0) begin
            src_valid = 1'b0;
            stall_left--;
        end else begin
            src_valid = (src_q.size() > 0);
            src_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    end

    // Pin monitor: records completed writes and counts protocol violations
    logic [19:0] wlog_a[$];
    logic [7:0]  wlog_d[$];
    int          prot_err, done_cnt, oe_cycles, we_w;
    logic        prev_we, prev_ce, prev_doe;
    logic [19:0] prev_a, strobe_a;
    logic [7:0]  prev_d, strobe_d;
    always @(negedge hwclk) begin
        if (reset) begin
            prev_we = 1'b1;
            we_w    = 0;
        end else begin
            if (bus_oe) oe_cycles++;
            if (done) done_cnt++;
            if (!we_n) begin
                if (prev_we) begin
                    if (a_out !== prev_a || d_out !== prev_d || prev_ce !== 1'b0 || prev_doe !== 1'b1)
                        prot_err++;
                    strobe_a = a_out;
                    strobe_d = d_out;
                end
                if (a_out !== strobe_a || d_out !== strobe_d || ce_n || !oe_n || !d_oe || !bus_oe)
                    prot_err++;
                we_w++;
            end else if (!prev_we) begin
                if (we_w != WE) prot_err++;
                if (a_out !== strobe_a || d_out !== strobe_d || ce_n || !d_oe) prot_err++;
                wlog_a.push_back(a_out);
                wlog_d.push_back(d_out);
                mem[a_out[9:0]] = d_out;
                we_w = 0;
            end
            if (!bus_oe && (!ce_n || !oe_n || !we_n || d_oe)) prot_err++;
            if (src_ready && !src_valid && (!bus_oe || !we_n)) prot_err++;
            prev_we  = we_n;
            prev_ce  = ce_n;
            prev_doe = d_oe;
            prev_a   = a_out;
            prev_d   = d_out;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] src_bytes[LEN];

    task automatic clear_mon();
        wlog_a.delete();
        wlog_d.delete();
        prot_err  = 0;
        done_cnt  = 0;
        oe_cycles = 0;
        n_cons    = 0;
    endtask

    task automatic pulse_start();
        @(negedge hwclk) start = 1'b1;
        @(negedge hwclk) start = 1'b0;
    endtask

    task automatic run_load(input string tag, input int ack_dly, input int s_at, input int s_len,
                            input bit dup_start, input bit drop_ack, input int bad_idx);
        int          k;
        logic [7:0]  wsum, rsum;
        bit          exp_fail;
        clear_mon();
        stall_at     = s_at;
        stall_left   = s_len;
        corrupt_en   = (bad_idx >= 0);
        corrupt_addr = BASE + 20'(bad_idx);
        for (int i = 0; i < LEN; i++) src_q.push_back(src_bytes[i]);
        pulse_start();
        chk({tag, ":req"}, {busreq_n, busy, fail}, 3'b010);
        repeat (ack_dly) @(negedge hwclk);
        busack_n = 1'b0;
        k = 0;
        while (!bus_oe && k < 20) begin
            @(negedge hwclk);
            k++;
        end
        chk({tag, ":ack_lat"}, k, 3);
        if (dup_start) pulse_start();
        if (drop_ack) begin
            repeat (3) @(negedge hwclk);
            busack_n = 1'b1;
        end
        k = 0;
        while (done_cnt == 0 && k < 2000) begin
            @(negedge hwclk);
            k++;
        end
        repeat (3) @(negedge hwclk);
        chk({tag, ":done_once"}, done_cnt, 1);
        busack_n = 1'b1;
        repeat (4) @(negedge hwclk);
        chk({tag, ":released"}, {busreq_n, bus_oe, busy, done_cnt[3:0]}, 7'b100_0001);
        chk({tag, ":nwr"}, wlog_a.size(), LEN);
        for (int i = 0; i < LEN && i < wlog_a.size(); i++)
            chk({tag, ":wr"}, {wlog_a[i], wlog_d[i]}, {BASE + 20'(i), src_bytes[i]});
        chk({tag, ":protocol"}, prot_err, 0);
        if (s_len == 0)
            chk({tag, ":bus_cycles"}, oe_cycles, 1 + LEN * (3 + WE) + (RB ? 2 * LEN : 0));
        wsum = 8'h00;
        rsum = 8'h00;
        for (int i = 0; i < LEN; i++) begin
            wsum += src_bytes[i];
            rsum += src_bytes[i] ^ ((i == bad_idx) ? 8'h01 : 8'h00);
        end
        exp_fail = RB && (wsum != rsum);
        chk({tag, ":fail"}, fail, exp_fail);
    endtask

    task automatic rand_bytes();
        for (int i = 0; i < LEN; i++) src_bytes[i] = 8'($urandom_range(0, 255));
    endtask

    localparam logic [37:0] IDLE_VEC = {10'b1_0_0_1_1_1_0_0_0_0, 20'h0, 8'h0};

    initial begin
        int k;
        reset = 1'b1; start = 1'b0; busack_n = 1'b1;
        src_valid = 1'b0; src_data = 8'h00;
        corrupt_en = 1'b0; corrupt_addr = '0;
        stall_at = -1; stall_left = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        clear_mon();
        repeat (3) @(negedge hwclk);
        reset = 1'b0;

        for (int c = 0; c < 20; c++) begin
            @(negedge hwclk);
            chk("idle", {busreq_n, bus_oe, d_oe, ce_n, oe_n, we_n, busy, done, fail, src_ready,
                         a_out, d_out}, IDLE_VEC);
        end
        chk("idle_done", done_cnt, 0);

        src_bytes[0] = 8'hA5; src_bytes[1] = 8'h5A; src_bytes[2] = 8'h00; src_bytes[3] = 8'hFF;
        run_load("L1", 5, -1, 0, 1'b0, 1'b0, -1);

        rand_bytes();
        run_load("L2stall", $urandom_range(0, 8), 2, 10, 1'b0, 1'b0, -1);

        rand_bytes();
        run_load("L3busy", $urandom_range(0, 8), -1, 0, 1'b1, 1'b1, -1);
        repeat (5) @(negedge hwclk);
        chk("L3_no_restart", {busreq_n, busy}, 2'b10);

        // Reset while byte 2 is being strobed
        rand_bytes();
        clear_mon();
        stall_at = -1;
        for (int i = 0; i < LEN; i++) src_q.push_back(src_bytes[i]);
        pulse_start();
        busack_n = 1'b0;
        k = 0;
        while (!(wlog_a.size() == 2 && !we_n) && k < 200) begin
            @(negedge hwclk);
            k++;
        end
        chk("rst_reached_strobe", k < 200, 1'b1);
        reset = 1'b1;
        @(negedge hwclk);
        chk("rst_outputs", {busreq_n, bus_oe, d_oe, ce_n, oe_n, we_n, busy, done, fail, src_ready,
                            a_out, d_out}, IDLE_VEC);
        @(negedge hwclk);
        reset    = 1'b0;
        busack_n = 1'b1;
        src_q.delete();
        repeat (4) @(negedge hwclk);
        chk("rst_writes", wlog_a.size(), 2);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_protocol", prot_err, 0);

        rand_bytes();
        run_load("L4post", $urandom_range(0, 8), -1, 0, 1'b0, 1'b0, -1);

        if (RB) begin
            rand_bytes();
            run_load("L5bad", $urandom_range(0, 8), -1, 0, 1'b0, 1'b0, 1);
            repeat (5) @(negedge hwclk);
            chk("L5_fail_held", fail, 1'b1);
            rand_bytes();
            run_load("L6clean", $urandom_range(0, 8), -1, 0, 1'b0, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
